// File: rtl/ram_port_arbiter.sv
// Arbitrates the fetch and load/store ports onto one single-port RAM and routes each read response back.
// Default is round-robin; define RAM_ARB_DATA_PRIO_EN for fixed data priority.
module ram_port_arbiter #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MAX_WAIT   = 4
) (
   input  logic                      clk,
   input  logic                      rstn_i,
   input  logic                      instr_req_i,
   input  logic [ADDR_WIDTH-1:0]     instr_addr_i,
   output logic                      instr_gnt_o,
   output logic                      instr_rvalid_o,
   output logic [DATA_WIDTH-1:0]     instr_rdata_o,
   input  logic                      data_req_i,
   input  logic                      data_we_i,
   input  logic [DATA_WIDTH/8-1:0]   data_be_i,
   input  logic [ADDR_WIDTH-1:0]     data_addr_i,
   input  logic [DATA_WIDTH-1:0]     data_wdata_i,
   output logic                      data_gnt_o,
   output logic                      data_rvalid_o,
   output logic [DATA_WIDTH-1:0]     data_rdata_o,
   output logic                      ram_en_o,
   output logic                      ram_we_o,
   output logic [DATA_WIDTH/8-1:0]   ram_be_o,
   output logic [ADDR_WIDTH-1:0]     ram_addr_o,
   output logic [DATA_WIDTH-1:0]     ram_wdata_o,
   input  logic [DATA_WIDTH-1:0]     ram_rdata_i
);

   localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
   localparam int unsigned CNT_WIDTH = 4;
   localparam logic [CNT_WIDTH-1:0] WAIT_LIMIT = CNT_WIDTH'(MAX_WAIT);
   localparam logic [CNT_WIDTH-1:0] WAIT_SAT   = '1;

   typedef enum logic {
      OWNER_INSTR = 1'b0,
      OWNER_DATA  = 1'b1
   } owner_e;

   logic [CNT_WIDTH-1:0] instr_wait_q, instr_wait_d;
   logic [CNT_WIDTH-1:0] data_wait_q, data_wait_d;
   logic                 rsp_valid_q, rsp_valid_d;
   owner_e               rsp_owner_q, rsp_owner_d;
   logic                 instr_starved, data_starved;
   logic                 instr_win, data_win;
`ifndef RAM_ARB_DATA_PRIO_EN
   owner_e               last_owner_q, last_owner_d;
`endif

   // Winner selection: starvation override first, then the conflict policy.
   always_comb begin
      instr_starved = (instr_wait_q >= WAIT_LIMIT);
      data_starved  = (data_wait_q >= WAIT_LIMIT);
      instr_win     = 1'b0;
      data_win      = 1'b0;
      if (instr_req_i && data_req_i) begin
         if (instr_starved && !data_starved) begin
            instr_win = 1'b1;
         end else if (data_starved && !instr_starved) begin
            data_win = 1'b1;
`ifdef RAM_ARB_DATA_PRIO_EN
         end else begin
            data_win = 1'b1;
`else
         end else if (last_owner_q == OWNER_INSTR) begin
            data_win = 1'b1;
         end else begin
            instr_win = 1'b1;
`endif
         end
      end else begin
         instr_win = instr_req_i;
         data_win  = data_req_i;
      end
   end

   assign instr_gnt_o = instr_win & rstn_i;
   assign data_gnt_o  = data_win & rstn_i;
   assign ram_en_o    = instr_gnt_o | data_gnt_o;

   // Request mux onto the RAM; idle drives zeros.
   always_comb begin
      ram_we_o    = 1'b0;
      ram_be_o    = '0;
      ram_addr_o  = '0;
      ram_wdata_o = '0;
      if (data_gnt_o) begin
         ram_we_o    = data_we_i;
         ram_be_o    = data_be_i;
         ram_addr_o  = data_addr_i;
         ram_wdata_o = data_wdata_i;
      end else if (instr_gnt_o) begin
         ram_be_o   = {BE_WIDTH{1'b1}};
         ram_addr_o = instr_addr_i;
      end
   end

   // Next-state for wait counters, response tracking and ownership history.
   always_comb begin
      instr_wait_d = '0;
      data_wait_d  = '0;
      rsp_valid_d  = instr_gnt_o | data_gnt_o;
      rsp_owner_d  = data_gnt_o ? OWNER_DATA : OWNER_INSTR;
      if (instr_req_i && !instr_gnt_o) begin
         instr_wait_d = (instr_wait_q == WAIT_SAT) ? WAIT_SAT : instr_wait_q + CNT_WIDTH'(1);
      end
      if (data_req_i && !data_gnt_o) begin
         data_wait_d = (data_wait_q == WAIT_SAT) ? WAIT_SAT : data_wait_q + CNT_WIDTH'(1);
      end
`ifndef RAM_ARB_DATA_PRIO_EN
      last_owner_d = last_owner_q;
      if (data_gnt_o) begin
         last_owner_d = OWNER_DATA;
      end else if (instr_gnt_o) begin
         last_owner_d = OWNER_INSTR;
      end
`endif
   end

   always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
         instr_wait_q <= '0;
         data_wait_q  <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_owner_q  <= OWNER_INSTR;
`ifndef RAM_ARB_DATA_PRIO_EN
         last_owner_q <= OWNER_INSTR;
`endif
      end else begin
         instr_wait_q <= instr_wait_d;
         data_wait_q  <= data_wait_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_owner_q  <= rsp_owner_d;
`ifndef RAM_ARB_DATA_PRIO_EN
         last_owner_q <= last_owner_d;
`endif
      end
   end

   // Response steering: only the owner sees rvalid and RAM data.
   assign instr_rvalid_o = rsp_valid_q && (rsp_owner_q == OWNER_INSTR);
   assign data_rvalid_o  = rsp_valid_q && (rsp_owner_q == OWNER_DATA);
   assign instr_rdata_o  = instr_rvalid_o ? ram_rdata_i : '0;
   assign data_rdata_o   = data_rvalid_o ? ram_rdata_i : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM plus a rule-level arbitration/response model.
module tb_ram_port_arbiter;

   logic        clk = 1'b0;
   logic        rstn_i;
   logic        instr_req_i;
   logic [15:0] instr_addr_i;
   logic        instr_gnt_o, instr_rvalid_o;
   logic [31:0] instr_rdata_o;
   logic        data_req_i, data_we_i;
   logic [3:0]  data_be_i;
   logic [15:0] data_addr_i;
   logic [31:0] data_wdata_i;
   logic        data_gnt_o, data_rvalid_o;
   logic [31:0] data_rdata_o;
   logic        ram_en_o, ram_we_o;
   logic [3:0]  ram_be_o;
   logic [15:0] ram_addr_o;
   logic [31:0] ram_wdata_o;
   bit   [31:0] ram_rdata;

   localparam int MAX_WAIT = 4;

   ram_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32), .MAX_WAIT(MAX_WAIT)) dut (
      .clk(clk), .rstn_i(rstn_i),
      .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
      .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
      .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
      .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
      .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
      .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
      .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata)
   );

   always #5 clk = ~clk;

   // Behavioural sp_ram: 256 words, byte enables, 1-cycle read latency.
   bit [31:0] ram_mem [256];
   always @(posedge clk) begin
      if (ram_en_o) begin
         if (ram_we_o) begin
            for (int b = 0; b < 4; b++)
               if (ram_be_o[b]) ram_mem[ram_addr_o[9:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
         end else begin
            ram_rdata <= ram_mem[ram_addr_o[9:2]];
         end
      end
   end

   int checks, errors;

   // Reference model state (0 = none, 1 = instr, 2 = data)
   bit [31:0]   m_mem [256];
   int          m_iwait, m_dwait, m_last;
   bit          exp_v, exp_store;
   int          exp_own;
   logic [31:0] exp_data;
   int          last_win;
   logic        obs_ig, obs_dg, obs_irv, obs_drv;
   logic [31:0] obs_ird, obs_drd;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input bit ir, input bit dr);
      bit is, ds;
      if (!ir && !dr) return 0;
      if (ir && !dr) return 1;
      if (dr && !ir) return 2;
      is = (m_iwait >= MAX_WAIT);
      ds = (m_dwait >= MAX_WAIT);
      if (is && !ds) return 1;
      if (ds && !is) return 2;
`ifdef RAM_ARB_DATA_PRIO_EN
      return 2;
`else
      return (m_last == 1) ? 2 : 1;
`endif
   endfunction

   // One clock cycle: drive, check mid-cycle against the model, advance the model.
   task automatic cycle(input bit rn, input bit ir, input logic [15:0] ia,
                        input bit dr, input bit dwe, input logic [3:0] dbe,
                        input logic [15:0] da, input logic [31:0] dwd);
      int win, idx;
      rstn_i = rn; instr_req_i = ir; instr_addr_i = ia;
      data_req_i = dr; data_we_i = dwe; data_be_i = dbe; data_addr_i = da; data_wdata_i = dwd;
      @(negedge clk);
      if (!rn) begin
         m_iwait = 0; m_dwait = 0; m_last = 1; exp_v = 0; win = 0;
      end else begin
         win = pick(ir, dr);
      end
      obs_ig = instr_gnt_o; obs_dg = data_gnt_o; obs_irv = instr_rvalid_o;
      obs_drv = data_rvalid_o; obs_ird = instr_rdata_o; obs_drd = data_rdata_o;
      check("instr_gnt", 32'(instr_gnt_o), 32'(win == 1));
      check("data_gnt", 32'(data_gnt_o), 32'(win == 2));
      check("ram_en", 32'(ram_en_o), 32'(win != 0));
      check("ram_we", 32'(ram_we_o), 32'(win == 2 && dwe));
      if (rn) begin
         check("ram_be", 32'(ram_be_o), (win == 1) ? 32'hF : (win == 2) ? 32'(dbe) : 32'h0);
         check("ram_addr", 32'(ram_addr_o), (win == 1) ? 32'(ia) : (win == 2) ? 32'(da) : 32'h0);
         check("ram_wdata", ram_wdata_o, (win == 2) ? dwd : 32'h0);
      end
      check("instr_rvalid", 32'(instr_rvalid_o), 32'(exp_v && exp_own == 1));
      check("data_rvalid", 32'(data_rvalid_o), 32'(exp_v && exp_own == 2));
      check("instr_rdata", instr_rdata_o, (exp_v && exp_own == 1) ? exp_data : 32'h0);
      if (!(exp_v && exp_own == 2 && exp_store))
         check("data_rdata", data_rdata_o, (exp_v && exp_own == 2) ? exp_data : 32'h0);
      if (rn) begin
         m_iwait = (!ir || win == 1) ? 0 : ((m_iwait < 15) ? m_iwait + 1 : 15);
         m_dwait = (!dr || win == 2) ? 0 : ((m_dwait < 15) ? m_dwait + 1 : 15);
         if (win != 0) m_last = win;
         exp_v = (win != 0); exp_own = win; exp_store = (win == 2) && dwe;
         idx = (win == 1) ? int'(ia[9:2]) : int'(da[9:2]);
         exp_data = m_mem[idx];
         if (exp_store)
            for (int b = 0; b < 4; b++)
               if (dbe[b]) m_mem[idx][8*b +: 8] = dwd[8*b +: 8];
      end
      last_win = win;
      @(posedge clk);
      #1;
   endtask

   bit          ip, dp, pwe, prn;
   logic [15:0] pia, pda;
   logic [3:0]  pbe;
   logic [31:0] pwd;
   logic [5:0]  gseq, rseq, exp_seq;
   int          nconf, irv_cnt, dg_cnt;

   initial begin
      checks = 0; errors = 0;
      m_iwait = 0; m_dwait = 0; m_last = 1; exp_v = 0; exp_own = 0; exp_store = 0;
      exp_data = '0; last_win = 0;

      // Reset, then reset asserted while a fetch response is outstanding
      repeat (3) cycle(0, 0, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0);
      cycle(1, 1, 16'h80, 0, 0, 4'h0, 16'h0, 32'h0);
      check("first_fetch_gnt", 32'(obs_ig), 32'h1);
      cycle(0, 1, 16'h80, 0, 0, 4'h0, 16'h0, 32'h0);
      check("rst_gnt", 32'(obs_ig), 32'h0);
      check("rst_rvalid", 32'(obs_irv), 32'h0);
      cycle(1, 0, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0);
      check("post_rst_rvalid", 32'(obs_irv | obs_drv), 32'h0);

      // Preload word 0x40 then fetch it
      cycle(1, 0, 16'h0, 1, 1, 4'hF, 16'h40, 32'hDEADBEEF);
      cycle(1, 1, 16'h40, 0, 0, 4'h0, 16'h0, 32'h0);
      check("single_gnt", 32'(obs_ig), 32'h1);
      cycle(1, 0, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0);
      check("single_rvalid", 32'(obs_irv), 32'h1);
      check("single_rdata", obs_ird, 32'hDEADBEEF);

      // Byte store then load back
      cycle(1, 0, 16'h0, 1, 1, 4'b0010, 16'h10, 32'h0000AB00);
      check("bstore_gnt", 32'(obs_dg), 32'h1);
      cycle(1, 0, 16'h0, 1, 0, 4'hF, 16'h10, 32'h0);
      check("bstore_rvalid", 32'(obs_drv), 32'h1);
      cycle(1, 0, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0);
      check("bload_rdata", obs_drd, 32'h0000AB00);

      // Both ports request continuously from reset
      cycle(0, 0, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0);
      gseq = '0; rseq = '0;
      for (int i = 0; i < 6; i++) begin
         cycle(1, 1, 16'h40, 1, 0, 4'hF, 16'h10, 32'h0);
         gseq[5-i] = obs_dg;
         if (i > 0) rseq[6-i] = obs_drv;
      end
      cycle(1, 0, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0);
      rseq[0] = obs_drv;
`ifdef RAM_ARB_DATA_PRIO_EN
      exp_seq = 6'b111101;
`else
      exp_seq = 6'b101010;
`endif
      check("conflict_grant_seq", 32'(gseq), 32'(exp_seq));
      check("conflict_rvalid_seq", 32'(rseq), 32'(exp_seq));

      // Fetch request withdrawn before grant while data keeps winning
      cycle(0, 0, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0);
`ifdef RAM_ARB_DATA_PRIO_EN
      nconf = 2;
`else
      nconf = 1;
`endif
      irv_cnt = 0; dg_cnt = 0;
      for (int i = 0; i < nconf + 4; i++) begin
         cycle(1, i < nconf, 16'h40, 1, 0, 4'hF, 16'h10, 32'h0);
         irv_cnt += int'(obs_irv); dg_cnt += int'(obs_dg);
      end
      cycle(1, 0, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0);
      irv_cnt += int'(obs_irv);
      check("withdraw_no_instr_rvalid", 32'(irv_cnt), 32'h0);
      check("withdraw_data_grants", 32'(dg_cnt), 32'(nconf + 4));

      // Randomized traffic honouring the hold-until-grant protocol
      ip = 0; dp = 0; pia = '0; pda = '0; pwe = 0; pbe = 4'hF; pwd = '0;
      for (int n = 0; n < 500; n++) begin
         if (last_win == 1) ip = 0;
         if (last_win == 2) dp = 0;
         if (ip && $urandom_range(0, 7) == 0) ip = 0;
         else if (!ip && $urandom_range(0, 1) == 1) begin
            ip = 1; pia = 16'($urandom_range(0, 31)) << 2;
         end
         if (dp && $urandom_range(0, 7) == 0) dp = 0;
         else if (!dp && $urandom_range(0, 2) != 0) begin
            dp = 1; pda = 16'($urandom_range(0, 31)) << 2; pwe = 1'($urandom);
            pbe = 4'($urandom_range(1, 15)); pwd = $urandom;
         end
         prn = ($urandom_range(0, 99) != 0);
         cycle(prn, ip, pia, dp, pwe, pbe, pda, pwd);
      end
      cycle(1, 0, 16'h0, 0, 0, 4'h0, 16'h0, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Shares the single-port data/instruction RAM (`sp_ram`, 1-cycle read latency, byte enables) between the core's instruction-fetch port and its load/store port. It uses a req/gnt/rvalid handshake, so at most one access is issued to the RAM per cycle. The block sits between the core and the RAM. It arbitrates between the two requesters, prevents starvation, and routes each read response back to the port that issued it.

## Interface

**Parameters**
- `ADDR_WIDTH`, default 16: byte address width, shared by both ports and the RAM.
- `DATA_WIDTH`, default 32: word width; byte enables are `DATA_WIDTH/8` bits wide.
- `MAX_WAIT`, default 4: consecutive denied cycles allowed for a pending port before it is forced to win; range 1..15.

**Ports** (clock and reset first)
- `clk` in 1: clock.
- `rstn_i` in 1: reset, asynchronous, active-low.
- `instr_req_i` in 1: fetch request.
- `instr_addr_i` in `ADDR_WIDTH`: fetch byte address.
- `instr_gnt_o` out 1: fetch accepted this cycle.
- `instr_rvalid_o` out 1: fetch response valid.
- `instr_rdata_o` out `DATA_WIDTH`: fetch read data.
- `data_req_i` in 1: load/store request.
- `data_we_i` in 1: 1 = store.
- `data_be_i` in `DATA_WIDTH/8`: store byte enables.
- `data_addr_i` in `ADDR_WIDTH`: load/store byte address.
- `data_wdata_i` in `DATA_WIDTH`: store data.
- `data_gnt_o` out 1: load/store accepted this cycle.
- `data_rvalid_o` out 1: load/store response valid.
- `data_rdata_o` out `DATA_WIDTH`: load read data.
- `ram_en_o` out 1: RAM access enable.
- `ram_we_o` out 1: RAM write enable.
- `ram_be_o` out `DATA_WIDTH/8`: RAM byte enables.
- `ram_addr_o` out `ADDR_WIDTH`: RAM byte address.
- `ram_wdata_o` out `DATA_WIDTH`: RAM write data.
- `ram_rdata_i` in `DATA_WIDTH`: RAM read data, valid the cycle after the access.

## Operation

**Grant (combinational)**
- At most one grant per cycle; `ram_en_o` equals the OR of the two grants.
- When a port is granted, its request is muxed onto the `ram_*` outputs.
- Instruction accesses always drive `ram_we_o = 0` and `ram_be_o` = all ones.
- With no request: `ram_en_o = 0`, `ram_we_o = 0`, and `ram_addr_o`, `ram_wdata_o`, `ram_be_o` are all 0.

**Arbitration policy (default: round-robin)**
- A `last_owner` register tracks which port won last; its reset value is INSTR, so DATA wins the first conflict.
- When both ports request, the port that is not `last_owner` wins.
- A single requester always wins.

**Starvation counters**
- Each port has a 4-bit wait counter.
- The counter increments on any cycle where that port requests and is not granted, saturating at 15.
- It clears on that port's grant, or on any cycle that port does not request.
- A port whose counter is ≥ `MAX_WAIT` wins unconditionally.
- If both ports are at the threshold, round-robin decides between them.

**Response tracking**
- Registers `rsp_valid` and `rsp_owner` capture the grant at the clock edge.
- The next cycle, the owning port sees `*_rvalid_o = 1` and `*_rdata_o = ram_rdata_i`.
- The other port's `rdata` is 0.
- Stores also produce `rvalid`; their `rdata` is don't-care.

**Requester protocol**
- A requester must hold `req` and all request signals stable until `gnt` is seen.
- A request may be withdrawn before grant without error.

## Timing

- **Grant:** same cycle as `req`, 0 cycles of latency.
- **Response:** `rvalid` exactly 1 cycle after `gnt`.
- **Throughput:** back-to-back grants to the same port give 1 access per cycle.
- **Reset values:** all registers clear. `rvalid`, `rdata`, `gnt` and `ram_en_o` are all 0 while `rstn_i` is low, with grants gated by `rstn_i`.
- **Reset mid-operation:** any pending response is discarded and no `rvalid` is issued after reset deasserts.
- **Simultaneous events:** a new grant and the response to the previous grant occur in the same cycle; they are independent and may belong to different ports.

## Configuration

- **Macro `RAM_ARB_DATA_PRIO_EN`, defined:** fixed priority replaces round-robin.
  - DATA wins every conflict.
  - INSTR still wins via its starvation counter at `MAX_WAIT`.
  - `last_owner` is not implemented.
- **Macro not defined:** round-robin as described above.

## Test plan

- **Reset behaviour:** assert `rstn_i = 0` mid-read with `instr_req_i = 1` → `instr_gnt_o = 0` and `ram_en_o = 0` during reset, and no `rvalid` in the first cycle after release.
- **Single read:** preload RAM word 0x40 = 0xDEADBEEF; `instr_req` to `addr = 0x40` → `gnt` in cycle N, then in N+1 `instr_rvalid_o = 1` and `instr_rdata_o = 0xDEADBEEF`.
- **Byte store then read:** data store with `be = 4'b0010`, `wdata = 0x0000AB00` to 0x10 (word previously 0) → `rvalid` at N+1; a load of 0x10 then returns 0x0000AB00.
- **Round-robin:** both ports hold `req` for 6 cycles → grants alternate D, I, D, I, D, I and each `rvalid` lands on the correct port.
- **Fixed priority (macro defined, `MAX_WAIT = 4`):** both ports request continuously → DATA is granted for 4 cycles, INSTR on the 5th, and the pattern repeats.
- **Request withdrawal:** INSTR requests for 2 cycles during DATA-only grants and then drops → its counter clears, no INSTR `rvalid` appears, and DATA keeps being granted.
